// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared funct3 encodings and LSU state type for the RV32I memory stage
package rv32i_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_e;
endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: picks the byte/half lane of a read word and sign/zero-extends it
//   rdata  in  read word from data memory
//   addr   in  low two bits of the effective address (lane select)
//   funct3 in  access size/sign
//   data   out extended load result
module lsu_load_extend
  import rv32i_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [1:0]       addr,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[WIDTH-1:16] : rdata[15:0];
    data = funct3 == F3_B  ? {{(WIDTH-8){b[7]}}, b} :
           funct3 == F3_H  ? {{(WIDTH-16){h[15]}}, h} :
           funct3 == F3_BU ? {{(WIDTH-8){1'b0}}, b} :
           funct3 == F3_HU ? {{(WIDTH-16){1'b0}}, h} : rdata;
  end
endmodule

// File: rtl/lsu.sv
// lsu: RV32I load/store unit with a single-outstanding req/ack data-memory port
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_valid, i_mem_rd, i_mem_wr    memory-stage instruction and its kind
//   i_funct3, i_alu_data, i_st_data access size/sign, effective address, store value
//   i_flush                        kill the memory-stage instruction
//   o_dmem_*, i_dmem_*             registered request port and its ack/read data
//   o_stall, o_done                pipeline hold and one-cycle completion pulse
//   o_ld_data, o_lsu_err           extended load result and error flag, valid with o_done
module lsu
  import rv32i_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_mem_rd,
  input  logic             i_mem_wr,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_alu_data,
  input  logic [WIDTH-1:0] i_st_data,
  input  logic             i_flush,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [WIDTH-1:0] o_dmem_addr,
  output logic [3:0]       o_dmem_be,
  output logic [WIDTH-1:0] o_dmem_wdata,
  input  logic             i_dmem_ack,
  input  logic [WIDTH-1:0] i_dmem_rdata,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_ld_data,
  output logic             o_lsu_err
);
  lsu_state_e       state;
  logic             kill;
  logic [2:0]       f3_q;
  logic [1:0]       a_q;
  logic [1:0]       a;
  logic             op;
  logic             err;
  logic [3:0]       be;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] ext;
  assign a = i_alu_data[1:0];
  // funct3[1:0] encodes size (00 B, 01 H, 10 W); 11 and 11x are never legal,
  // and the unsigned variants make no sense for stores.
  always_comb begin
    op = i_valid & (i_mem_rd | i_mem_wr) & ~i_flush;
    err = (i_funct3[1:0] == 2'b11) | (i_funct3[2] & (i_funct3[1] | i_mem_wr))
        | ((i_funct3[1:0] == 2'b01) & a[0]) | ((i_funct3[1:0] == 2'b10) & (a != 2'b00));
    be = i_funct3[1:0] == 2'b00 ? 4'b0001 << a :
         i_funct3[1:0] == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = i_funct3[1:0] == 2'b00 ? {4{i_st_data[7:0]}} :
            i_funct3[1:0] == 2'b01 ? {2{i_st_data[15:0]}} : i_st_data;
  end
  assign o_stall = i_valid & (i_mem_rd | i_mem_wr) & (state != DONE) & ~((state == IDLE) & i_flush);
  assign o_done  = state == DONE;
  lsu_load_extend #(.WIDTH(WIDTH)) u_ext (
    .rdata  (i_dmem_rdata),
    .addr   (a_q),
    .funct3 (f3_q),
    .data   (ext)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      kill         <= 1'b0;
      f3_q         <= 3'b000;
      a_q          <= 2'b00;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_be    <= 4'b0000;
      o_dmem_wdata <= '0;
      o_ld_data    <= '0;
      o_lsu_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (op) begin
            f3_q      <= i_funct3;
            a_q       <= a;
            o_lsu_err <= err;
            o_ld_data <= '0;
            if (err) state <= DONE;
            else begin
              state        <= REQ;
              o_dmem_req   <= 1'b1;
              o_dmem_we    <= i_mem_wr;
              o_dmem_addr  <= {i_alu_data[WIDTH-1:2], 2'b00};
              o_dmem_be    <= be;
              o_dmem_wdata <= wdata;
            end
          end
        end
        REQ: begin
          if (i_flush) kill <= 1'b1;
          // a flush arriving together with ack still kills the result
          if (i_dmem_ack) begin
            o_dmem_req <= 1'b0;
            o_ld_data  <= o_dmem_we ? '0 : ext;
            state      <= (kill | i_flush) ? IDLE : DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized checks of lsu against a behavioural access model
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst_n, valid, rd, wr, flush, ack;
  logic [2:0]  f3;
  logic [31:0] alu, st, rdata;
  logic        req, we, stall, done, lsu_err;
  logic [31:0] addr, wdata, ld_data;
  logic [3:0]  be;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_mem_rd(rd), .i_mem_wr(wr),
    .i_funct3(f3), .i_alu_data(alu), .i_st_data(st), .i_flush(flush),
    .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr), .o_dmem_be(be),
    .o_dmem_wdata(wdata), .i_dmem_ack(ack), .i_dmem_rdata(rdata),
    .o_stall(stall), .o_done(done), .o_ld_data(ld_data), .o_lsu_err(lsu_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit exp_err(input bit w, input logic [2:0] f, input logic [31:0] ad);
    bit bad;
    bad = (f == 3) || (f == 6) || (f == 7) || (w && (f == 4 || f == 5));
    return bad || (ad % size_of(f) != 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f, input logic [31:0] ad);
    int s;
    s = size_of(f);
    return 4'(((1 << s) - 1) << (ad % 4));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f, input logic [31:0] sd);
    int s;
    s = size_of(f);
    return s == 1 ? sd[7:0] * 32'h01010101 : s == 2 ? sd[15:0] * 32'h00010001 : sd;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] f, input logic [31:0] ad, input logic [31:0] rw);
    int s;
    logic [63:0] v;
    s = size_of(f);
    v = ({32'b0, rw} >> (8 * (ad % 4))) & ((64'd1 << (8 * s)) - 1);
    if (f < 4 && s < 4 && ((v >> (8 * s - 1)) & 64'd1) == 64'd1) v = v - (64'd1 << (8 * s));
    return v[31:0];
  endfunction

  task automatic run_op(input bit r, input bit w, input logic [2:0] f, input logic [31:0] ad,
                        input logic [31:0] sd, input logic [31:0] rw, input int wn, input int fl);
    bit e;
    bit killed;
    e = exp_err(w, f, ad);
    killed = fl >= 0 && fl <= wn;
    @(negedge clk);
    valid = 1; rd = r; wr = w; f3 = f; alu = ad; st = sd; flush = 0; ack = 0;
    #1;
    chk("accept_stall", stall, 1);
    chk("accept_req", req, 0);
    chk("accept_done", done, 0);
    if (e) begin
      @(negedge clk);
      ack = 1;
      #1;
      chk("err_done", done, 1);
      chk("err_flag", lsu_err, 1);
      chk("err_ld", ld_data, 0);
      chk("err_req", req, 0);
      chk("err_stall", stall, 0);
      @(negedge clk);
      valid = 0; ack = 0;
      #1;
      chk("err_after_done", done, 0);
      chk("err_after_req", req, 0);
    end else begin
      for (int k = 0; k <= wn; k++) begin
        @(negedge clk);
        ack = (k == wn); flush = (k == fl); rdata = rw;
        #1;
        chk("req_held", req, 1);
        chk("req_we", we, w);
        chk("req_addr", addr, {ad[31:2], 2'b00});
        chk("req_be", be, exp_be(f, ad));
        if (w) chk("req_wdata", wdata, exp_wd(f, sd));
        chk("req_stall", stall, 1);
        chk("req_done", done, 0);
      end
      @(negedge clk);
      ack = 0; flush = 0; rdata = $urandom;
      if (killed) begin
        valid = 0;
        #1;
        chk("kill_no_done", done, 0);
        chk("kill_req", req, 0);
        chk("kill_stall", stall, 0);
      end else begin
        #1;
        chk("done_pulse", done, 1);
        chk("done_ld", ld_data, w ? 32'd0 : exp_ld(f, ad, rw));
        chk("done_err", lsu_err, 0);
        chk("done_stall", stall, 0);
        chk("done_req", req, 0);
        @(negedge clk);
        valid = 0;
        #1;
        chk("done_once", done, 0);
      end
    end
  endtask

  initial begin
    rst_n = 0; valid = 0; rd = 0; wr = 0; flush = 0; ack = 0; f3 = 0; alu = 0; st = 0; rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ld", ld_data, 0);
    rst_n = 1;
    run_op(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, -1);
    run_op(1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 0, -1);
    run_op(1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 1, -1);
    run_op(1, 0, 3'b101, 32'h102, 0, 32'h80FF0000, 0, -1);
    run_op(1, 0, 3'b001, 32'h102, 0, 32'h80FF0000, 2, -1);
    run_op(0, 1, 3'b000, 32'h201, 32'h123456AB, 0, 3, -1);
    run_op(0, 1, 3'b001, 32'h202, 32'h123456AB, 0, 0, -1);
    run_op(0, 1, 3'b010, 32'h204, 32'h123456AB, 0, 1, -1);
    run_op(1, 0, 3'b010, 32'h102, 0, 0, 0, -1);
    run_op(0, 1, 3'b100, 32'h100, 5, 0, 0, -1);
    run_op(1, 0, 3'b111, 32'h100, 0, 0, 0, -1);
    run_op(1, 0, 3'b010, 32'h180, 0, 32'h11111111, 2, 1);
    run_op(1, 0, 3'b010, 32'h184, 0, 32'h22222222, 0, -1);
    run_op(1, 0, 3'b010, 32'h188, 0, 32'h33333333, 1, 1);
    run_op(1, 0, 3'b010, 32'h18C, 0, 32'h44444444, 0, -1);
    @(negedge clk);
    valid = 1; rd = 1; wr = 0; f3 = 3'b010; alu = 32'h300; ack = 0; flush = 0;
    @(negedge clk);
    #1;
    chk("mid_req_up", req, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1; valid = 0;
    #1;
    chk("post_rst_req", req, 0);
    chk("post_rst_we", we, 0);
    chk("post_rst_addr", addr, 0);
    chk("post_rst_be", be, 0);
    chk("post_rst_wdata", wdata, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_err", lsu_err, 0);
    chk("post_rst_ld", ld_data, 0);
    chk("post_rst_stall", stall, 0);
    run_op(1, 0, 3'b010, 32'h400, 0, 32'hCAFEF00D, 0, -1);
    for (int i = 0; i < 60; i++) begin
      bit r;
      int wn;
      int fl;
      r = 1'($urandom_range(0, 1));
      wn = $urandom_range(0, 3);
      fl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, wn) : -1;
      run_op(r, !r, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, wn, fl);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I pipeline's memory stage, directly downstream of the ALU. It takes the ALU result as the effective address and drives a single-outstanding request/acknowledge data-memory port. It generates byte enables and replicated store data, and returns sign- or zero-extended load data. It stalls the pipeline while an access is in flight and flags misaligned or illegal accesses without touching memory.

## Interface
- WIDTH, 32, data/address width; only 32 supported
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  memory-stage instruction valid
- i_mem_rd  in  1  instruction is a load
- i_mem_wr  in  1  instruction is a store; never both with i_mem_rd
- i_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- i_alu_data  in  WIDTH  effective address from ALU
- i_st_data  in  WIDTH  rs2 store value
- i_flush  in  1  kill current memory-stage instruction
- o_dmem_req  out  1  memory request, registered
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  WIDTH  word address, {addr[31:2],2'b00}
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  WIDTH  lane-replicated store data
- i_dmem_ack  in  1  access complete; rdata valid same cycle for reads
- i_dmem_rdata  in  WIDTH  read word
- o_stall  out  1  hold upstream stages
- o_done  out  1  one-cycle completion pulse
- o_ld_data  out  WIDTH  extended load result, valid with o_done
- o_lsu_err  out  1  misaligned/illegal-funct3 flag, valid with o_done

## Operation
- States: IDLE, REQ, DONE.
- IDLE: an operation is `i_valid & (i_mem_rd|i_mem_wr) & ~i_flush`.
  - Legal operation → REQ. Register req=1, we, addr, be, wdata.
  - Illegal operation → DONE with o_lsu_err=1 and o_ld_data=0. No request is issued.
- REQ: o_dmem_req and all request fields are held stable until i_dmem_ack.
  - On ack → DONE. o_ld_data is registered from extended rdata (0 for stores); req drops.
  - A new request is issued only from IDLE, so at most one is outstanding.
- DONE: o_done=1 for exactly one cycle, then → IDLE unconditionally.
- Flush in REQ sets a kill flag. The transaction still completes. On ack → IDLE directly with no o_done. The kill flag clears in IDLE.
- Flush in DONE is ignored; the result is already committed.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0. Illegal funct3: 011, 110, 111, and for stores also 100 and 101.
- Store byte enables and data:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
- Loads select the byte/half lane by addr[1:0]/addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through. Loads drive be by the same rule; we=0.

## Timing
- o_stall is combinational: `i_valid & (i_mem_rd|i_mem_wr) & state≠DONE & ~(state==IDLE & i_flush)`. It deasserts in DONE so the instruction advances on that edge.
- Latency with ack in the first REQ cycle: cycle 0 IDLE accept, cycle 1 REQ+ack, cycle 2 DONE/o_done. The next operation is accepted at cycle 3.
- An error path takes 2 cycles (IDLE, DONE).
- Each extra wait cycle of ack adds one cycle.
- i_dmem_ack outside REQ is ignored.
- Reset values: state IDLE; o_dmem_req, o_dmem_we, o_done, o_lsu_err = 0; o_dmem_addr, o_dmem_be, o_dmem_wdata, o_ld_data = 0.
- Reset mid-REQ drops req asynchronously. Memory must tolerate an abandoned request.

## Structure
- rv32i_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - typedef enum logic [1:0] lsu_state_e {IDLE, REQ, DONE}.
- Sub-module lsu_load_extend: combinational. Inputs are rdata, addr[1:0], funct3; output is the extended WIDTH result.
- The FSM, store formatting and registers live in lsu.

## Test plan
- LW addr 0x100, ack on cycle 1, rdata 0xDEADBEEF → o_done on cycle 2, o_ld_data 0xDEADBEEF, o_stall high on cycles 0–1 and low on cycle 2.
- LB addr 0x103, rdata 0x80FF_0000 → o_ld_data 0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x102 → 0x000080FF.
- SB addr 0x201, rs2 0x123456AB → addr 0x200, be 0010, wdata 0xABABABAB, we=1. The request is held through 3 wait cycles until ack.
- LW addr 0x102 → no o_dmem_req ever. o_done and o_lsu_err on cycle 1, o_ld_data 0.
- i_flush asserted in REQ, then ack → no o_done, state IDLE. A next LW is accepted the cycle after.
- i_rst_n low mid-REQ → o_dmem_req=0 immediately. After release, state is IDLE and all outputs are 0.
